// File: rtl/dtrig_former.sv
// Trigger former: turns the coincidence discriminator level into fixed-width
// trigger pulses with programmable dead time and saturating trigger/loss counters.
module dtrig_former #(
  parameter int DBITS = 10,
  parameter int PBITS = 4,
  parameter int CBITS = 32
) (
  input  logic             ADCCLK,
  input  logic             reset,
  input  logic             ddiscr,
  input  logic             inhibit,
  input  logic [PBITS-1:0] plen,
  input  logic [DBITS-1:0] deadtime,
  input  logic             cnt_clr,
  output logic             trig,
  output logic             busy,
  output logic [CBITS-1:0] trig_cnt,
  output logic [CBITS-1:0] lost_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             ddiscr_q;
  logic [PBITS-1:0] pcnt_q, pcnt_d;
  logic [DBITS-1:0] dcnt_q, dcnt_d;
  logic [CBITS-1:0] tcnt_q, tcnt_d;
  logic [CBITS-1:0] lcnt_q, lcnt_d;
  logic             rise, acc, lost;

  assign rise = ddiscr & ~ddiscr_q;

  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    acc     = 1'b0;
    lost    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          if (!inhibit) begin
            state_d = S_PULSE;
            trig_d  = 1'b1;
            // plen==0 behaves like plen==1
            pcnt_d  = (plen == '0) ? '0 : plen - PBITS'(1);
            acc     = 1'b1;
          end else begin
            lost = 1'b1;
          end
        end
      end
      S_PULSE: begin
        lost = rise;
        if (pcnt_q == '0) begin
          trig_d = 1'b0;
          if (deadtime == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DEAD;
            dcnt_d  = deadtime - DBITS'(1);
          end
        end else begin
          pcnt_d = pcnt_q - PBITS'(1);
        end
      end
      S_DEAD: begin
        lost = rise;
        if (dcnt_q == '0) state_d = S_IDLE;
        else              dcnt_d  = dcnt_q - DBITS'(1);
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 1'b0;
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    tcnt_d = tcnt_q;
    lcnt_d = lcnt_q;
    if (cnt_clr) begin
      tcnt_d = '0;
      lcnt_d = '0;
    end else begin
      if (acc  && (tcnt_q != '1)) tcnt_d = tcnt_q + CBITS'(1);
      if (lost && (lcnt_q != '1)) lcnt_d = lcnt_q + CBITS'(1);
    end
  end

  // ddiscr_q resets high so a level already present at release is not an edge.
  always_ff @(posedge ADCCLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      ddiscr_q <= 1'b1;
      pcnt_q   <= '0;
      dcnt_q   <= '0;
      tcnt_q   <= '0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      ddiscr_q <= ddiscr;
      pcnt_q   <= pcnt_d;
      dcnt_q   <= dcnt_d;
      tcnt_q   <= tcnt_d;
      lcnt_q   <= lcnt_d;
    end
  end

  assign trig     = trig_q;
  assign busy     = busy_q;
  assign trig_cnt = tcnt_q;
  assign lost_cnt = lcnt_q;

endmodule

// File: tb/tb_dtrig_former.sv
// Scoreboard bench for dtrig_former: stimulus queues expected pulse/busy widths,
// a monitor measures every trig pulse; counters are checked at directed points.
module tb_dtrig_former;
  localparam int DBITS = 10;
  localparam int PBITS = 4;
  localparam int CBITS = 4;

  logic             ADCCLK = 1'b0;
  logic             reset;
  logic             ddiscr;
  logic             inhibit;
  logic [PBITS-1:0] plen;
  logic [DBITS-1:0] deadtime;
  logic             cnt_clr;
  logic             trig;
  logic             busy;
  logic [CBITS-1:0] trig_cnt;
  logic [CBITS-1:0] lost_cnt;

  dtrig_former #(.DBITS(DBITS), .PBITS(PBITS), .CBITS(CBITS)) dut (
    .ADCCLK(ADCCLK), .reset(reset), .ddiscr(ddiscr), .inhibit(inhibit),
    .plen(plen), .deadtime(deadtime), .cnt_clr(cnt_clr),
    .trig(trig), .busy(busy), .trig_cnt(trig_cnt), .lost_cnt(lost_cnt)
  );

  always #5 ADCCLK = ~ADCCLK;

  typedef struct {int tlen; int blen;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge ADCCLK); #1; end
  endtask

  task automatic push(input int t, input int b);
    exp_t e;
    e.tlen = t;
    e.blen = b;
    q.push_back(e);
  endtask

  // bit i of bits is the ddiscr value sampled at the i-th following clock edge
  task automatic pat(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ddiscr = bits[i];
      tick();
    end
    ddiscr = 1'b0;
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // Monitor: measures trig and busy widths of each pulse, compares to queue head.
  exp_t cur;
  int   tcnt, bcnt;
  bit   tact = 0, bact = 0, tprev = 0;
  always @(negedge ADCCLK) begin
    if (reset) begin
      tact  = 0;
      bact  = 0;
      tprev = 0;
    end else begin
      if (trig && !tprev) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_trig: got pulse expected none at %0t", $time);
        end else begin
          cur  = q.pop_front();
          tact = 1;
          bact = 1;
          tcnt = 0;
          bcnt = 0;
        end
      end
      if (tact) begin
        if (trig) tcnt++;
        else begin
          chk("trig_width", tcnt, cur.tlen);
          tact = 0;
        end
      end
      if (bact) begin
        if (busy) bcnt++;
        else begin
          if (cur.blen >= 0) chk("busy_width", bcnt, cur.blen);
          bact = 0;
        end
      end
      tprev = trig;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ddiscr = 1'b0; inhibit = 1'b0; cnt_clr = 1'b0;
    plen = '0; deadtime = '0;
    tick(2);
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tcnt", int'(trig_cnt), 0);
    chk("rst_lcnt", int'(lost_cnt), 0);
    reset = 1'b0;
    tick(2);

    // single trigger, level held high
    plen = 4; deadtime = 10;
    ddiscr = 1'b1; push(4, 14);
    tick(20);
    ddiscr = 1'b0;
    tick(5);
    chk("single_tcnt", int'(trig_cnt), 1);
    chk("single_lcnt", int'(lost_cnt), 0);

    // dead-time rejection: edges 0,3,7,9; 7 lands on the DEAD->IDLE edge
    clr();
    plen = 2; deadtime = 5;
    push(2, 7); push(2, 7);
    pat(32'h289, 10);
    tick(12);
    chk("dead_tcnt", int'(trig_cnt), 2);
    chk("dead_lcnt", int'(lost_cnt), 2);

    // minimum period L+deadtime+1 = 8: edges 0 and 8 both accepted
    clr();
    push(2, 7); push(2, 7);
    pat(32'h101, 9);
    tick(12);
    chk("minper_tcnt", int'(trig_cnt), 2);
    chk("minper_lcnt", int'(lost_cnt), 0);

    // zero settings: period-2 toggling meets min period 2, all accepted
    clr();
    plen = 0; deadtime = 0;
    repeat (4) push(1, 1);
    pat(32'h55, 8);
    tick(4);
    chk("zero_tcnt", int'(trig_cnt), 4);
    chk("zero_lcnt", int'(lost_cnt), 0);

    // inhibit in IDLE, then inhibit raised mid-pulse
    clr();
    plen = 3; deadtime = 2;
    inhibit = 1'b1;
    pat(32'h15, 6);
    inhibit = 1'b0;
    push(3, 5);
    pat(32'h1, 1);
    tick(8);
    push(3, 5);
    ddiscr = 1'b1;
    tick();
    inhibit = 1'b1;
    tick(3);
    ddiscr = 1'b0;
    tick(6);
    inhibit = 1'b0;
    chk("inh_tcnt", int'(trig_cnt), 2);
    chk("inh_lcnt", int'(lost_cnt), 3);

    // saturation of both counters at 15
    clr();
    plen = 1; deadtime = 0;
    repeat (20) begin
      ddiscr = 1'b1; push(1, 1); tick();
      ddiscr = 1'b0; tick();
    end
    tick(2);
    chk("sat_tcnt", int'(trig_cnt), 15);
    inhibit = 1'b1;
    repeat (20) begin
      ddiscr = 1'b1; tick();
      ddiscr = 1'b0; tick();
    end
    inhibit = 1'b0;
    tick(2);
    chk("sat_lcnt", int'(lost_cnt), 15);
    chk("sat_hold_tcnt", int'(trig_cnt), 15);

    // clear coincident with an accepted edge: not counted, pulse still issued
    ddiscr = 1'b1; cnt_clr = 1'b1; push(1, 1);
    tick();
    ddiscr = 1'b0; cnt_clr = 1'b0;
    tick(3);
    chk("clr_tcnt", int'(trig_cnt), 0);
    chk("clr_lcnt", int'(lost_cnt), 0);

    // ddiscr high across reset release is not an edge
    ddiscr = 1'b1; reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("rel_trig", int'(trig), 0);
    chk("rel_busy", int'(busy), 0);
    chk("rel_tcnt", int'(trig_cnt), 0);
    ddiscr = 1'b0;
    tick(2);

    // reset asserted during DEAD clears busy and counters at once
    plen = 2; deadtime = 10;
    push(2, -1);
    pat(32'h1, 1);
    tick(4);
    chk("pre_rst_tcnt", int'(trig_cnt), 1);
    chk("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_tcnt", int'(trig_cnt), 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    push(2, 12);
    pat(32'h1, 1);
    tick(16);
    chk("post_rst_tcnt", int'(trig_cnt), 1);
    chk("post_rst_lcnt", int'(lost_cnt), 0);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
